// File: rtl/pattern_pkg.sv
// Shared mode encodings and colour constants for the parametrised VGA pattern generator.
package pattern_pkg;

    typedef enum logic [2:0] {
        MODE_BARS  = 3'd0,
        MODE_GRID  = 3'd1,
        MODE_GRAD  = 3'd2,
        MODE_CHECK = 3'd3,
        MODE_SOLID = 3'd4,
        MODE_MBAR  = 3'd5
    } mode_e;

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;

    // Colour-bar order, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/syncgen_p.sv
// Parametrised VGA raster counters with unregistered active / HS / VS region flags.
module syncgen_p #(
    parameter  int HPERIOD = 800,
    parameter  int HACT    = 640,
    parameter  int HFRONT  = 16,
    parameter  int HWIDTH  = 96,
    parameter  int VPERIOD = 525,
    parameter  int VACT    = 480,
    parameter  int VFRONT  = 10,
    parameter  int VWIDTH  = 2,
    localparam int HW      = $clog2(HPERIOD),
    localparam int VW      = $clog2(VPERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] hcnt_p0,
    output logic [VW-1:0] vcnt_p0,
    output logic          active_p0,
    output logic          hs_act_p0,
    output logic          vs_act_p0
);

    localparam logic [31:0] HACT_L   = 32'(HACT);
    localparam logic [31:0] VACT_L   = 32'(VACT);
    localparam logic [31:0] HS_START = 32'(HACT + HFRONT);
    localparam logic [31:0] HS_END   = 32'(HACT + HFRONT + HWIDTH);
    localparam logic [31:0] VS_START = 32'(VACT + VFRONT);
    localparam logic [31:0] VS_END   = 32'(VACT + VFRONT + VWIDTH);

    if (HACT + HFRONT + HWIDTH > HPERIOD) begin : g_hchk
        $error("syncgen_p: HACT+HFRONT+HWIDTH exceeds HPERIOD");
    end
    if (VACT + VFRONT + VWIDTH > VPERIOD) begin : g_vchk
        $error("syncgen_p: VACT+VFRONT+VWIDTH exceeds VPERIOD");
    end

    // Stage p0: raster position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_p0 <= '0;
            vcnt_p0 <= '0;
        end else if (hcnt_p0 == HW'(HPERIOD - 1)) begin
            hcnt_p0 <= '0;
            if (vcnt_p0 == VW'(VPERIOD - 1)) begin
                vcnt_p0 <= '0;
            end else begin
                vcnt_p0 <= vcnt_p0 + 1'b1;
            end
        end else begin
            hcnt_p0 <= hcnt_p0 + 1'b1;
        end
    end

    assign active_p0 = (32'(hcnt_p0) < HACT_L) && (32'(vcnt_p0) < VACT_L);
    assign hs_act_p0 = (32'(hcnt_p0) >= HS_START) && (32'(hcnt_p0) < HS_END);
    // VS follows the line counter, so it moves exactly at HCNT=0.
    assign vs_act_p0 = (32'(vcnt_p0) >= VS_START) && (32'(vcnt_p0) < VS_END);

endmodule

// File: rtl/pattern_gen.sv
// VGA test-pattern generator: raster timing, per-frame mode latching, pattern mux and
// a single registered output stage driving the encoder.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int HPERIOD    = 800,
    parameter int HACT       = 640,
    parameter int HFRONT     = 16,
    parameter int HWIDTH     = 96,
    parameter int VPERIOD    = 525,
    parameter int VACT       = 480,
    parameter int VFRONT     = 10,
    parameter int VWIDTH     = 2,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int GRID_LOG2  = 5,
    parameter int GRAD_SHIFT = 1,
    parameter int BAR_LOG2   = 4,
    parameter int SPEED      = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  MODE,
    input  logic [23:0] SOLID_RGB,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE,
    output logic        FRAME_START
);

    localparam int HW      = $clog2(HPERIOD);
    localparam int VW      = $clog2(VPERIOD);
    localparam int CW      = (HW + 1 > VW) ? HW + 1 : VW;
    localparam int AW      = HW + 2;
    localparam int BAR_W   = HACT / 8;
    localparam int BAR_LEN = 2 ** BAR_LOG2;

    if (HACT < 8) begin : g_bchk
        $error("pattern_gen: HACT must allow eight colour bars");
    end
    if (SPEED >= HACT) begin : g_schk
        $error("pattern_gen: SPEED must be smaller than HACT");
    end

    logic [HW-1:0] hcnt_p0;
    logic [VW-1:0] vcnt_p0;
    logic          active_p0;
    logic          hs_act_p0;
    logic          vs_act_p0;
    logic          frame_start_p0;

    logic [2:0]    mode_q;
    logic [23:0]   solid_q;
    logic [7:0]    fcnt_q;
    logic [AW-1:0] acc_q;

    logic [2:0]    mode_eff;
    logic [23:0]   solid_eff;
    logic [7:0]    fcnt_eff;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] pos_eff;

    logic [2:0]    bar_idx;
    logic          grid_on;
    logic [7:0]    grad_val;
    logic          chk_cell;
    logic          mbar_on;
    logic [23:0]   rgb_p0;

    logic [23:0]   rgb_p1;
    logic          de_p1;
    logic          hs_p1;
    logic          vs_p1;
    logic          fs_p1;

    syncgen_p #(
        .HPERIOD (HPERIOD),
        .HACT    (HACT),
        .HFRONT  (HFRONT),
        .HWIDTH  (HWIDTH),
        .VPERIOD (VPERIOD),
        .VACT    (VACT),
        .VFRONT  (VFRONT),
        .VWIDTH  (VWIDTH)
    ) u_syncgen (
        .clk       (CLK),
        .rst_n     (RST),
        .hcnt_p0   (hcnt_p0),
        .vcnt_p0   (vcnt_p0),
        .active_p0 (active_p0),
        .hs_act_p0 (hs_act_p0),
        .vs_act_p0 (vs_act_p0)
    );

    assign frame_start_p0 = (hcnt_p0 == '0) && (vcnt_p0 == '0);

    // On the frame-start clock the incoming values are used directly, so every pixel of a
    // frame, including (0,0), sees the same mode, colour, frame count and bar position.
    assign acc_sum   = acc_q + AW'(SPEED);
    assign acc_next  = (acc_sum >= AW'(HACT)) ? acc_sum - AW'(HACT) : acc_sum;
    assign mode_eff  = frame_start_p0 ? MODE : mode_q;
    assign solid_eff = frame_start_p0 ? SOLID_RGB : solid_q;
    assign fcnt_eff  = frame_start_p0 ? fcnt_q + 8'd1 : fcnt_q;
    assign pos_eff   = frame_start_p0 ? acc_next : acc_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q  <= MODE_BARS;
            solid_q <= '0;
            fcnt_q  <= '0;
            acc_q   <= '0;
        end else if (frame_start_p0) begin
            mode_q  <= MODE;
            solid_q <= SOLID_RGB;
            fcnt_q  <= fcnt_eff;
            acc_q   <= acc_next;
        end
    end

    // The last bar absorbs any remainder when HACT is not a multiple of eight.
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (32'(hcnt_p0) >= 32'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign grid_on  = (hcnt_p0[GRID_LOG2-1:0] == '0) || (vcnt_p0[GRID_LOG2-1:0] == '0) ||
                      (32'(hcnt_p0) == 32'(HACT - 1)) || (32'(vcnt_p0) == 32'(VACT - 1));
    assign grad_val = 8'(hcnt_p0 >> GRAD_SHIFT);
    assign chk_cell = 1'(((CW'(hcnt_p0) + CW'(fcnt_eff)) ^ CW'(vcnt_p0)) >> GRID_LOG2);
    assign mbar_on  = (AW'(hcnt_p0) >= pos_eff) && (AW'(hcnt_p0) < pos_eff + AW'(BAR_LEN));

    always_comb begin
        rgb_p0 = BLACK;
        if (active_p0) begin
            case (mode_eff)
                MODE_BARS:  rgb_p0 = bar_colour(bar_idx);
                MODE_GRID:  rgb_p0 = grid_on ? WHITE : BLACK;
                MODE_GRAD:  rgb_p0 = {3{grad_val}};
                MODE_CHECK: rgb_p0 = chk_cell ? WHITE : BLACK;
                MODE_SOLID: rgb_p0 = solid_eff;
                MODE_MBAR:  rgb_p0 = mbar_on ? WHITE : BLUE;
                default:    rgb_p0 = BLACK;
            endcase
        end
    end

    // Stage p1: registered outputs, all aligned one clock behind the counters
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rgb_p1 <= '0;
            de_p1  <= 1'b0;
            hs_p1  <= ~HS_POL;
            vs_p1  <= ~VS_POL;
            fs_p1  <= 1'b0;
        end else begin
            rgb_p1 <= rgb_p0;
            de_p1  <= active_p0;
            hs_p1  <= hs_act_p0 ? HS_POL : ~HS_POL;
            vs_p1  <= vs_act_p0 ? VS_POL : ~VS_POL;
            fs_p1  <= frame_start_p0;
        end
    end

    assign VGA_R       = rgb_p1[23:16];
    assign VGA_G       = rgb_p1[15:8];
    assign VGA_B       = rgb_p1[7:0];
    assign VGA_DE      = de_p1;
    assign VGA_HS      = hs_p1;
    assign VGA_VS      = vs_p1;
    assign FRAME_START = fs_p1;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen on a shrunken raster, compared cycle by cycle with
// an arithmetic model of the timing and pattern rules.
module tb_pattern_gen;

    localparam int HP   = 26;
    localparam int HA   = 18;
    localparam int HF   = 2;
    localparam int HWD  = 3;
    localparam int VP   = 10;
    localparam int VA   = 6;
    localparam int VF   = 1;
    localparam int VWD  = 2;
    localparam bit HSP  = 1'b0;
    localparam bit VSP  = 1'b1;
    localparam int GL   = 2;
    localparam int GS   = 1;
    localparam int BL   = 2;
    localparam int SPD  = 5;
    localparam int FP   = HP * VP;
    localparam int CELL = 1 << GL;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [2:0]  MODE = 3'd0;
    logic [23:0] SOLID_RGB = 24'h0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_DE, FRAME_START;

    int errors = 0;
    int checks = 0;
    int t = 0;
    int fs_cnt = 0;
    logic [2:0]  m_mode = 3'd0;
    logic [23:0] m_solid = 24'h0;

    pattern_gen #(
        .HPERIOD(HP), .HACT(HA), .HFRONT(HF), .HWIDTH(HWD),
        .VPERIOD(VP), .VACT(VA), .VFRONT(VF), .VWIDTH(VWD),
        .HS_POL(HSP), .VS_POL(VSP), .GRID_LOG2(GL), .GRAD_SHIFT(GS),
        .BAR_LOG2(BL), .SPEED(SPD)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .SOLID_RGB(SOLID_RGB),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    // Expected {RGB, HS, VS, DE, FRAME_START} for raster step tt (0 = first clock after reset).
    function automatic logic [27:0] model(input int tt, input logic [2:0] md, input logic [23:0] sd);
        int x, y, k, p, b;
        logic [23:0] c;
        logic hs, vs, de, fs;
        x  = tt % HP;
        y  = (tt / HP) % VP;
        k  = tt / FP + 1;
        de = (x < HA) && (y < VA);
        hs = (x >= HA + HF && x < HA + HF + HWD) ? HSP : !HSP;
        vs = (y >= VA + VF && y < VA + VF + VWD) ? VSP : !VSP;
        fs = (x == 0) && (y == 0);
        c  = 24'h0;
        if (de) begin
            case (md)
                3'd0: begin
                    b = x / (HA / 8);
                    if (b > 7) b = 7;
                    c = BARS[b];
                end
                3'd1: c = (x % CELL == 0 || y % CELL == 0 || x == HA - 1 || y == VA - 1) ? 24'hFFFFFF : 24'h0;
                3'd2: begin
                    b = (x / (1 << GS)) % 256;
                    c = {3{8'(b)}};
                end
                3'd3: c = (((x + k % 256) / CELL + y / CELL) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                3'd4: c = sd;
                3'd5: begin
                    p = (k * SPD) % HA;
                    c = (x >= p && x < p + (1 << BL)) ? 24'hFFFFFF : 24'h0000FF;
                end
                default: c = 24'h0;
            endcase
        end
        return {c, hs, vs, de, fs};
    endfunction

    task automatic step();
        logic [27:0] exp_v, obs_v;
        @(posedge CLK);
        @(negedge CLK);
        if (t % FP == 0) begin
            m_mode  = MODE;
            m_solid = SOLID_RGB;
        end
        exp_v = model(t, m_mode, m_solid);
        obs_v = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL pixel t=%0d x=%0d y=%0d mode=%0d observed=%h expected=%h",
                   t, t % HP, (t / HP) % VP, m_mode, obs_v, exp_v);
        end
        if (FRAME_START) fs_cnt++;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset(input string tag);
        logic [27:0] obs_v;
        obs_v = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START};
        checks++;
        assert (obs_v === {24'h0, !HSP, !VSP, 2'b00}) else begin
            errors++;
            $error("FAIL reset_%s observed=%h expected=%h", tag, obs_v, {24'h0, !HSP, !VSP, 2'b00});
        end
    endtask

    task automatic check_frames(input string tag, input int want);
        checks++;
        assert (fs_cnt === want) else begin
            errors++;
            $error("FAIL frame_count_%s observed=%0d expected=%0d", tag, fs_cnt, want);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            check_reset("hold");
        end
        RST = 1'b1;
        t = 0;
        fs_cnt = 0;

        // Colour bars, two full frames.
        run(2 * FP);

        // Solid colour; a mid-frame switch to bars only takes effect next frame.
        MODE = 3'd4;
        SOLID_RGB = 24'h123456;
        run(3 * HP);
        MODE = 3'd0;
        run(FP - 3 * HP);
        run(FP);

        MODE = 3'd1; run(FP);
        MODE = 3'd2; run(FP);
        MODE = 3'd6; run(FP);
        MODE = 3'd7; run(FP);

        // Random modes and colours, with a random mid-frame change that must be ignored.
        for (int f = 0; f < 12; f++) begin
            MODE = 3'($urandom_range(0, 7));
            SOLID_RGB = 24'($urandom);
            n = int'($urandom_range(1, FP - 1));
            run(n);
            MODE = 3'($urandom_range(0, 7));
            SOLID_RGB = 24'($urandom);
            run(FP - n);
        end

        // Moving bar over many accumulator wraps.
        MODE = 3'd5;
        run(40 * FP);
        check_frames("run", t / FP);

        // Scrolling checker long enough for the 8-bit frame counter to wrap.
        MODE = 3'd3;
        run(200 * FP);

        // Asynchronous reset in the middle of a line.
        run(2 * HP + 10);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1 check_reset("async");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_reset("held");
        end
        RST = 1'b1;
        t = 0;
        fs_cnt = 0;
        MODE = 3'd5;
        run(2 * FP);
        check_frames("after_reset", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
